fb_fifo_drain: RTL

Downstream consumer of the framebuffer FIFO. Pulls 64-bit pixel words from the FIFO's Avalon-MM read slave, gathers them into fixed-length bursts and writes them to framebuffer memory through a burst-capable Avalon-MM write master. One `start` pulse transfers one full frame, beginning at a programmable byte address.

---
 rtl/fb_fifo_drain_pkg.sv | 13 +
 rtl/fb_fifo_drain_buffer.sv | 29 ++
 rtl/fb_fifo_drain.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/fb_fifo_drain_pkg.sv
// Shared types and constants for the framebuffer FIFO drain engine.
package fb_fifo_drain_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        BURST = 2'd2,
        DONE  = 2'd3
    } drain_state_t;

    localparam int unsigned BYTES_PER_WORD = 8;

endpackage

// File: rtl/fb_fifo_drain_buffer.sv
// Burst staging register file: one synchronous write port, one combinational read port.
module fb_fifo_drain_buffer #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned IDX_W = $clog2(DEPTH)
) (
    input  logic             clock,
    input  logic             aclr,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic [63:0]      wr_data,
    input  logic [IDX_W-1:0] rd_idx,
    output logic [63:0]      rd_data
);

    logic [63:0] regs [DEPTH];

    always_ff @(posedge clock or posedge aclr) begin
        if (aclr) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                regs[i] <= '0;
            end
        end else if (wr_en) begin
            regs[wr_idx] <= wr_data;
        end
    end

    assign rd_data = regs[rd_idx];

endmodule

// File: rtl/fb_fifo_drain.sv
// Drains framebuffer FIFO words into fixed-length Avalon-MM write bursts, one frame per start.
module fb_fifo_drain
    import fb_fifo_drain_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH  = 32,
    parameter int unsigned BURST_LEN   = 8,
    parameter int unsigned FRAME_WORDS = 192000
) (
    input  logic                          clock,
    input  logic                          aclr,
    input  logic                          start,
    input  logic [ADDR_WIDTH-1:0]         fb_base,
    output logic                          busy,
    output logic                          done,
    output logic                          fifo_read,
    input  logic [63:0]                   fifo_readdata,
    input  logic                          fifo_waitrequest,
    output logic [ADDR_WIDTH-1:0]         mem_address,
    output logic [$clog2(BURST_LEN):0]    mem_burstcount,
    output logic                          mem_write,
    output logic [63:0]                   mem_writedata,
    output logic [7:0]                    mem_byteenable,
    input  logic                          mem_waitrequest
);

    localparam int unsigned IDX_W  = $clog2(BURST_LEN);
    localparam int unsigned CNT_W  = IDX_W + 1;
    localparam int unsigned WCNT_W = $clog2(FRAME_WORDS + 1);

    drain_state_t          state_q, state_d;
    logic [CNT_W-1:0]      issued_q;
    logic [CNT_W-1:0]      captured_q;
    logic [IDX_W-1:0]      beat_q;
    logic                  rd_pend_q;
    logic [WCNT_W-1:0]     word_cnt_q;
    logic [ADDR_WIDTH-1:0] addr_q;

    logic                  take_start;
    logic                  beat_adv;
    logic                  burst_end;
    logic                  frame_last;
    logic [63:0]           buf_rd_data;

    assign frame_last = (word_cnt_q + WCNT_W'(BURST_LEN)) == WCNT_W'(FRAME_WORDS);

    always_ff @(posedge clock or posedge aclr) begin
        if (aclr) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state plus state-decoded handshakes; fifo_read must react to waitrequest in-cycle.
    always_comb begin
        state_d    = state_q;
        busy       = 1'b0;
        done       = 1'b0;
        fifo_read  = 1'b0;
        mem_write  = 1'b0;
        take_start = 1'b0;
        beat_adv   = 1'b0;
        burst_end  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    take_start = 1'b1;
                    state_d    = FILL;
                end
            end
            FILL: begin
                busy      = 1'b1;
                fifo_read = !fifo_waitrequest && (issued_q < CNT_W'(BURST_LEN));
                if (rd_pend_q && (captured_q == CNT_W'(BURST_LEN - 1))) begin
                    state_d = BURST;
                end
            end
            BURST: begin
                busy      = 1'b1;
                mem_write = 1'b1;
                if (!mem_waitrequest) begin
                    beat_adv = 1'b1;
                    if (beat_q == IDX_W'(BURST_LEN - 1)) begin
                        burst_end = 1'b1;
                        state_d   = frame_last ? DONE : FILL;
                    end
                end
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Fill/burst counters, frame word counter and burst address.
    always_ff @(posedge clock or posedge aclr) begin
        if (aclr) begin
            issued_q   <= '0;
            captured_q <= '0;
            beat_q     <= '0;
            rd_pend_q  <= 1'b0;
            word_cnt_q <= '0;
            addr_q     <= '0;
        end else begin
            rd_pend_q <= fifo_read;
            if (take_start) begin
                addr_q     <= fb_base;
                word_cnt_q <= '0;
                issued_q   <= '0;
                captured_q <= '0;
                beat_q     <= '0;
            end else if (burst_end) begin
                addr_q     <= addr_q + ADDR_WIDTH'(BURST_LEN * BYTES_PER_WORD);
                word_cnt_q <= word_cnt_q + WCNT_W'(BURST_LEN);
                issued_q   <= '0;
                captured_q <= '0;
                beat_q     <= '0;
            end else begin
                if (fifo_read) begin
                    issued_q <= issued_q + CNT_W'(1);
                end
                if (rd_pend_q) begin
                    captured_q <= captured_q + CNT_W'(1);
                end
                if (beat_adv) begin
                    beat_q <= beat_q + IDX_W'(1);
                end
            end
        end
    end

    fb_fifo_drain_buffer #(
        .DEPTH (BURST_LEN),
        .IDX_W (IDX_W)
    ) u_buffer (
        .clock   (clock),
        .aclr    (aclr),
        .wr_en   (rd_pend_q),
        .wr_idx  (captured_q[IDX_W-1:0]),
        .wr_data (fifo_readdata),
        .rd_idx  (beat_q),
        .rd_data (buf_rd_data)
    );

    assign mem_address    = addr_q;
    assign mem_burstcount = mem_write ? CNT_W'(BURST_LEN) : '0;
    assign mem_writedata  = mem_write ? buf_rd_data : '0;
    assign mem_byteenable = 8'hFF;

endmodule
